// File: rtl/mem_ctrl.sv
// CPU-side memory responder: unified RAM behind the instruction and data ports,
// plus a memory-mapped countdown timer that raises the core's alert interrupt.
module mem_ctrl #(
   parameter int          ADDR_W     = 12,
   parameter logic [31:0] TIMER_BASE = 32'hFFFF_FF00,
   parameter string       INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_instr_addr,
   output logic [31:0] mem_instr_data,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_wr,
   output logic [31:0] mem_rd_data,
   output logic        alert
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } tmr_state_t;

   logic [31:0]       r_ram [0:DEPTH-1];
   logic [31:0]       r_instr_data, r_rd_data;
   logic [31:0]       r_load, r_count;
   logic              r_auto, r_pend, r_alert;
   tmr_state_t        r_state, w_state_nxt;

   logic [ADDR_W-1:0] w_d_idx, w_i_idx;
   logic              w_d_ram, w_i_ram, w_d_tmr;
   logic              w_ram_wr, w_ctrl_wr, w_load_wr, w_expire, w_en;
   logic [31:0]       w_instr_nxt, w_rd_nxt, w_ctrl_rd;
   logic [31:0]       w_load_nxt, w_count_nxt;
   logic              w_auto_nxt, w_pend_nxt, w_alert_nxt;
   logic              w_unused_bits;

   assign w_unused_bits = ^{mem_addr[1:0], mem_instr_addr[1:0]};

   assign w_d_idx   = mem_addr[ADDR_W+1:2];
   assign w_i_idx   = mem_instr_addr[ADDR_W+1:2];
   assign w_d_ram   = (mem_addr[31:ADDR_W+2] == '0);
   assign w_i_ram   = (mem_instr_addr[31:ADDR_W+2] == '0);
   assign w_d_tmr   = (mem_addr[31:4] == TIMER_BASE[31:4]);
   assign w_ram_wr  = mem_wr && w_d_ram;
   assign w_load_wr = mem_wr && w_d_tmr && (mem_addr[3:2] == 2'd0);
   assign w_ctrl_wr = mem_wr && w_d_tmr && (mem_addr[3:2] == 2'd1);
   assign w_expire  = (r_state == RUN) && (r_count == 32'd0);
   assign w_en      = (r_state == RUN);
   assign w_ctrl_rd = {29'd0, r_pend, r_auto, w_en};

   always @(posedge clk) begin
      if (w_ram_wr) begin
         r_ram[w_d_idx] <= mem_wr_data;
      end
   end

   // Write-first bypass: a store to the fetched/loaded word is seen in the same cycle.
   always_comb begin
      w_instr_nxt = 32'd0;
      w_rd_nxt    = 32'd0;
      if (!w_i_ram) begin
         w_instr_nxt = 32'd0;
      end else if (w_ram_wr && (w_i_idx == w_d_idx)) begin
         w_instr_nxt = mem_wr_data;
      end else begin
         w_instr_nxt = r_ram[w_i_idx];
      end
      if (w_d_ram) begin
         w_rd_nxt = mem_wr ? mem_wr_data : r_ram[w_d_idx];
      end else if (w_d_tmr) begin
         case (mem_addr[3:2])
            2'd0:    w_rd_nxt = r_load;
            2'd1:    w_rd_nxt = w_ctrl_rd;
            2'd2:    w_rd_nxt = r_count;
            default: w_rd_nxt = 32'd0;
         endcase
      end else begin
         w_rd_nxt = 32'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_load       <= 32'd0;
         r_count      <= 32'd0;
         r_auto       <= 1'b0;
         r_pend       <= 1'b0;
         r_alert      <= 1'b0;
         r_instr_data <= 32'd0;
         r_rd_data    <= 32'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_load       <= w_load_nxt;
         r_count      <= w_count_nxt;
         r_auto       <= w_auto_nxt;
         r_pend       <= w_pend_nxt;
         r_alert      <= w_alert_nxt;
         r_instr_data <= w_instr_nxt;
         r_rd_data    <= w_rd_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, EXPIRED: begin
            if (w_ctrl_wr && mem_wr_data[0]) w_state_nxt = RUN;
            else                             w_state_nxt = r_state;
         end
         RUN: begin
            if (w_ctrl_wr && !mem_wr_data[0]) w_state_nxt = IDLE;
            else if (w_expire)                w_state_nxt = r_auto ? RUN : EXPIRED;
            else                              w_state_nxt = RUN;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Timer datapath; PEND clear is applied first so an expiry set in the same cycle wins.
   always_comb begin
      w_load_nxt  = w_load_wr ? mem_wr_data : r_load;
      w_auto_nxt  = w_ctrl_wr ? mem_wr_data[1] : r_auto;
      w_pend_nxt  = (w_ctrl_wr && mem_wr_data[2]) ? 1'b0 : r_pend;
      w_count_nxt = r_count;
      w_alert_nxt = 1'b0;
      case (r_state)
         IDLE, EXPIRED: begin
            if (w_ctrl_wr && mem_wr_data[0]) w_count_nxt = r_load;
            else                             w_count_nxt = r_count;
         end
         RUN: begin
            if (w_ctrl_wr && !mem_wr_data[0]) begin
               w_count_nxt = r_count;
            end else if (w_expire) begin
               w_pend_nxt  = 1'b1;
               w_alert_nxt = 1'b1;
               w_count_nxt = r_auto ? r_load : 32'd0;
            end else begin
               w_count_nxt = r_count - 32'd1;
            end
         end
         default: w_count_nxt = r_count;
      endcase
   end

   assign mem_instr_data = r_instr_data;
   assign mem_rd_data    = r_rd_data;
   assign alert          = r_alert;
endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized + directed bench for mem_ctrl: stimulus pushes predicted responses
// from an arithmetic reference model into a queue that a monitor drains each cycle.
module tb_mem_ctrl;
   localparam logic [31:0] TB = 32'hFFFF_FF00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_instr_addr = 32'd0;
   logic [31:0] mem_instr_data;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wr_data = 32'd0;
   logic        mem_wr = 1'b0;
   logic [31:0] mem_rd_data;
   logic        alert;

   mem_ctrl #(.ADDR_W(12), .TIMER_BASE(TB), .INIT_FILE("")) dut (
      .clk(clk), .rst(rst),
      .mem_instr_addr(mem_instr_addr), .mem_instr_data(mem_instr_data),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr),
      .mem_rd_data(mem_rd_data), .alert(alert)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] rd; logic [31:0] ins; logic al; } exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: RAM as an array, timer as "edge number of next expiry".
   logic [31:0] mram [0:4095];
   longint n = 0;
   bit     m_run, m_auto, m_pend;
   logic [31:0] m_load, m_hold;
   longint m_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
      end
   endtask

   function automatic bit is_ram(input logic [31:0] a);
      return a < 32'h0000_4000;
   endfunction

   function automatic bit is_tmr(input logic [31:0] a);
      return a[31:4] == TB[31:4];
   endfunction

   function automatic logic [31:0] count_now();
      if (m_run) return 32'(m_exp - 1 - n);
      return m_hold;
   endfunction

   task automatic model_reset();
      m_run = 1'b0; m_auto = 1'b0; m_pend = 1'b0; m_load = 32'd0; m_hold = 32'd0; m_exp = 0;
   endtask

   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [31:0] ia);
      exp_t e;
      longint eg;
      bit ctrl_wr, load_wr, old_auto;
      logic [31:0] old_load;
      mem_addr = a; mem_wr_data = wd; mem_wr = w; mem_instr_addr = ia;
      eg = n + 1;
      e.rd = 32'd0; e.ins = 32'd0; e.al = 1'b0;
      if (is_ram(a)) e.rd = w ? wd : mram[a[13:2]];
      else if (is_tmr(a)) begin
         case (a[3:2])
            2'd0: e.rd = m_load;
            2'd1: e.rd = {29'd0, m_pend, m_auto, m_run};
            2'd2: e.rd = count_now();
            default: e.rd = 32'd0;
         endcase
      end
      if (is_ram(ia)) e.ins = (w && is_ram(a) && a[13:2] == ia[13:2]) ? wd : mram[ia[13:2]];
      if (w && is_ram(a)) mram[a[13:2]] = wd;
      ctrl_wr = w && is_tmr(a) && a[3:2] == 2'd1;
      load_wr = w && is_tmr(a) && a[3:2] == 2'd0;
      old_auto = m_auto; old_load = m_load;
      if (ctrl_wr) begin
         m_auto = wd[1];
         if (wd[2]) m_pend = 1'b0;
      end
      if (m_run) begin
         if (ctrl_wr && !wd[0]) begin
            m_hold = count_now(); m_run = 1'b0;
         end else if (m_exp == eg) begin
            e.al = 1'b1; m_pend = 1'b1;
            if (old_auto) m_exp = eg + longint'(old_load) + 1;
            else begin m_run = 1'b0; m_hold = 32'd0; end
         end
      end else if (ctrl_wr && wd[0]) begin
         m_run = 1'b1; m_exp = eg + longint'(old_load) + 1;
      end
      if (load_wr) m_load = wd;
      @(posedge clk);
      n = eg;
      q.push_back(e);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(TB + 32'd4, 32'd0, 1'b0, 32'h0000_0010);
   endtask

   // Monitor: one predicted response per clock, compared away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_data", mem_rd_data, e.rd);
            chk("instr_data", mem_instr_data, e.ins);
            chk("alert", {31'd0, alert}, {31'd0, e.al});
         end
      end
   end

   initial begin
      logic [31:0] a, ia, wd;
      logic w;
      int r;
      bit found;
      model_reset();
      #3;
      chk("reset_instr", mem_instr_data, 32'd0);
      chk("reset_rd", mem_rd_data, 32'd0);
      chk("reset_alert", {31'd0, alert}, 32'd0);
      @(posedge clk); #3;
      chk("reset_held_instr", mem_instr_data, 32'd0);
      rst = 1'b0;

      // Fill the words the bench later reads so every expectation is defined.
      for (int i = 0; i < 16; i++) step(32'(4 * i), $urandom, 1'b1, 32'h8000_0000);
      step(32'h0, 32'h1234_5678, 1'b1, 32'h8000_0000);
      step(32'h8000_0000, 32'd0, 1'b0, 32'h0);

      // Store/load, write-first on both ports, byte-offset aliasing.
      step(32'h10, 32'hDEAD_BEEF, 1'b1, 32'h10);
      step(32'h13, 32'd0, 1'b0, 32'h12);
      // Unmapped store then load; word 0 must survive.
      step(32'h8000_0000, 32'hCAFE_F00D, 1'b1, 32'h0);
      step(32'h8000_0000, 32'd0, 1'b0, 32'h0);
      step(32'h0, 32'd0, 1'b0, 32'h4000_0000);

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         wd = $urandom;
         w = 1'($urandom_range(0, 1));
         if (r < 6) a = 32'($urandom_range(0, 63));
         else if (r < 8) a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
         else begin a = TB + 32'(4 * $urandom_range(0, 3)); w = 1'b0; end
         ia = ($urandom_range(0, 4) == 0) ? 32'hFFFF_0000 : 32'($urandom_range(0, 63));
         step(a, wd, w, ia);
      end

      // One-shot timer.
      step(TB + 32'd0, 32'd3, 1'b1, 32'h0);
      step(TB + 32'd4, 32'h1, 1'b1, 32'h0);
      idle(8);
      step(TB + 32'd8, 32'd0, 1'b0, 32'h0);
      step(TB + 32'd4, 32'h4, 1'b1, 32'h0);
      idle(2);

      // Auto-reload, LOAD change mid-run, PEND clear racing expiry, stop at expiry.
      step(TB + 32'd0, 32'd2, 1'b1, 32'h0);
      step(TB + 32'd4, 32'h3, 1'b1, 32'h0);
      idle(4);
      step(TB + 32'd0, 32'd5, 1'b1, 32'h0);
      idle(16);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_run && m_exp == n + 1) found = 1'b1; else idle(1);
      end
      if (!found) begin checks++; errors++; $display("FAIL expiry_sync_pend: no expiry found"); end
      step(TB + 32'd4, 32'h7, 1'b1, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_run && m_exp == n + 1) found = 1'b1; else idle(1);
      end
      if (!found) begin checks++; errors++; $display("FAIL expiry_sync_stop: no expiry found"); end
      step(TB + 32'd4, 32'h0, 1'b1, 32'h0);
      idle(10);

      // LOAD=0 with AUTO alerts every cycle.
      step(TB + 32'd0, 32'd0, 1'b1, 32'h0);
      step(TB + 32'd4, 32'h3, 1'b1, 32'h0);
      idle(5);
      step(TB + 32'd4, 32'h0, 1'b1, 32'h0);

      // Asynchronous reset while COUNT == 7.
      step(TB + 32'd0, 32'd20, 1'b1, 32'h0);
      step(TB + 32'd4, 32'h3, 1'b1, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_run && count_now() == 32'd7) found = 1'b1; else idle(1);
      end
      if (!found) begin checks++; errors++; $display("FAIL count_seven: COUNT never reached 7"); end
      #6;
      rst = 1'b1;
      #1;
      chk("async_alert", {31'd0, alert}, 32'd0);
      chk("async_rd", mem_rd_data, 32'd0);
      chk("async_instr", mem_instr_data, 32'd0);
      model_reset();
      @(posedge clk); #3;
      rst = 1'b0;
      step(TB + 32'd8, 32'd0, 1'b0, 32'h0);
      step(TB + 32'd4, 32'd0, 1'b0, 32'h0);
      idle(30);

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL queue_drain: %0d left expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
